// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity receive/check path.
package odd_parity_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEFAULT_DATA_WIDTH   = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Widest {parity, data} message the helper accepts; narrower messages
    // are zero-extended, which leaves the XOR reduction unchanged.
    localparam int MAX_MSG_WIDTH = 64;

    // 1 when the message holds an even number of ones (odd parity broken).
    function automatic logic odd_parity_error(input logic [MAX_MSG_WIDTH-1:0] msg);
        return ~^msg;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps. Ticks flag the
// mid-bit point and the end of a bit period; restart forces the count to 0.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_COUNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: restart wins, otherwise wrap at the end of the bit period.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (count_q == LAST_COUNT) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign half_tick = (count_q == HALF_COUNT);
    assign full_tick = (count_q == LAST_COUNT);

endmodule

// File: rtl/odd_parity_serial_receiver.sv
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB first, odd
// parity bit, stop bit. Delivers {parity, data} plus error flags through a
// valid/ready output register with overrun reporting.
//
// Handshake: a frame is transferred on a rising edge where msg_valid and
// msg_ready are both 1. While msg_valid is 1 the message and flags hold
// still; msg_ready while msg_valid is 0 has no effect.
module odd_parity_serial_receiver
    import odd_parity_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    output logic [DATA_WIDTH:0]   parity_message,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    // Frame tracking.
    rx_state_t state_q, state_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  parity_q, parity_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;

    // Output register.
    logic [DATA_WIDTH:0]   msg_q, msg_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    // Timer interface and FSM decode.
    logic timer_restart;
    logic half_tick;
    logic full_tick;
    logic start_ok;
    logic data_en;
    logic parity_en;
    logic stop_en;

    logic [MAX_MSG_WIDTH-1:0] msg_ext;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart   (timer_restart),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start bit is confirmed at mid-bit, later bits are
    // one full period apart.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!serial_in) state_d = START;
            START:   if (half_tick) state_d = serial_in ? IDLE : DATA;
            DATA:    if (full_tick && (bit_idx_q == LAST_BIT)) state_d = PARITY;
            PARITY:  if (full_tick) state_d = STOP;
            STOP:    if (full_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. The timer is held at 0 while the line idles high so the
    // falling-edge cycle counts as timer 0; it is re-zeroed at the start
    // sample so data samples land on full-period ticks.
    always_comb begin
        timer_restart = 1'b0;
        start_ok      = 1'b0;
        data_en       = 1'b0;
        parity_en     = 1'b0;
        stop_en       = 1'b0;
        unique case (state_q)
            IDLE:    timer_restart = serial_in;
            START:   begin
                timer_restart = half_tick;
                start_ok      = half_tick && !serial_in;
            end
            DATA:    data_en   = full_tick;
            PARITY:  parity_en = full_tick;
            STOP:    stop_en   = full_tick;
            default: timer_restart = 1'b1;
        endcase
    end

    // Sample capture: data bits LSB first, then parity and stop.
    always_comb begin
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        stop_d    = stop_q;
        done_d    = stop_en;
        if (start_ok) begin
            bit_idx_d = '0;
        end
        if (data_en) begin
            data_d[bit_idx_q] = serial_in;
            if (bit_idx_q != LAST_BIT) begin
                bit_idx_d = bit_idx_q + 1'b1;
            end
        end
        if (parity_en) begin
            parity_d = serial_in;
        end
        if (stop_en) begin
            stop_d = serial_in;
        end
    end

    // Sample capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
        end
    end

    // Output register next values: load a completed frame if the slot is
    // free or being drained this edge, otherwise drop it and flag overrun.
    always_comb begin
        msg_ext = '0;
        msg_ext[DATA_WIDTH:0] = {parity_q, data_q};
        msg_d   = msg_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (done_q) begin
            if (!valid_q || msg_ready) begin
                msg_d   = {parity_q, data_q};
                perr_d  = odd_parity_error(msg_ext);
                ferr_d  = ~stop_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && msg_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            msg_q   <= msg_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parity_message = msg_q;
    assign msg_valid      = valid_q;
    assign parity_error   = perr_q;
    assign framing_error  = ferr_q;
    assign overrun        = ovr_q;

endmodule
